// File: rtl/decode_prefix_collect.sv
// Legacy-prefix / 0x0F-escape stripper ahead of the operand decoder.
// Ports: byte stream in (byte_*), one held instruction out (instr_*, prefix_*).
module decode_prefix_collect #(
   parameter int MAX_PREFIXES = 4,
   parameter int BODY_BYTES   = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   input  logic                    byte_last,
   output logic                    byte_ready,
   output logic                    instr_valid,
   input  logic                    instr_ready,
   output logic [8*BODY_BYTES-1:0] unescaped_instr,
   output logic                    escaped_0f,
   output logic                    prefix_operand_16bit,
   output logic                    prefix_address_16bit,
   output logic [1:0]              prefix_rep,
   output logic                    prefix_lock,
   output logic [2:0]              prefix_seg,
   output logic [3:0]              body_len,
   output logic                    instr_bad
);

   localparam int          W        = 8 * BODY_BYTES;
   localparam int          PCW      = $clog2(MAX_PREFIXES + 2);
   localparam logic [3:0]  BODY_MAX = 4'(BODY_BYTES);
   localparam logic [PCW-1:0] PC_MAX = PCW'(MAX_PREFIXES);
   localparam logic [PCW-1:0] PC_SAT = PCW'(MAX_PREFIXES + 1);

   typedef enum logic [1:0] {
      S_PREFIX, S_ESCAPE, S_BODY, S_HOLD
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   instr_q, instr_d;
   logic           esc_q, esc_d;
   logic           op16_q, op16_d;
   logic           adr16_q, adr16_d;
   logic [1:0]     rep_q, rep_d;
   logic           lock_q, lock_d;
   logic [2:0]     seg_q, seg_d;
   logic [3:0]     len_q, len_d;
   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic           bad_q, bad_d;

   logic xfer;
   logic is_pfx;
   logic accept;

   assign xfer   = byte_valid & byte_ready;
   assign accept = instr_valid & instr_ready;
   assign is_pfx = byte_in inside {8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
                                   8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_PREFIX;
      else        state_q <= state_d;
   end

   // next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_PREFIX: begin
            if (xfer) begin
               if (byte_last)            state_d = S_HOLD;
               else if (is_pfx)          state_d = S_PREFIX;
               else if (byte_in == 8'h0F) state_d = S_ESCAPE;
               else                      state_d = S_BODY;
            end
         end
         S_ESCAPE, S_BODY: begin
            if (xfer) state_d = byte_last ? S_HOLD : S_BODY;
         end
         S_HOLD: begin
            if (instr_ready) state_d = S_PREFIX;
         end
         default: state_d = S_PREFIX;
      endcase
   end

   // outputs decoded from state
   always_comb begin
      byte_ready  = (state_q != S_HOLD);
      instr_valid = (state_q == S_HOLD);
   end

   // datapath next values
   always_comb begin
      instr_d = instr_q;
      esc_d   = esc_q;
      op16_d  = op16_q;
      adr16_d = adr16_q;
      rep_d   = rep_q;
      lock_d  = lock_q;
      seg_d   = seg_q;
      len_d   = len_q;
      pcnt_d  = pcnt_q;
      bad_d   = bad_q;
      if (accept) begin
         instr_d = '0;
         esc_d   = 1'b0;
         op16_d  = 1'b0;
         adr16_d = 1'b0;
         rep_d   = 2'b00;
         lock_d  = 1'b0;
         seg_d   = 3'b111;
         len_d   = 4'd0;
         pcnt_d  = '0;
         bad_d   = 1'b0;
      end else if (xfer) begin
         if (state_q == S_PREFIX && is_pfx) begin
            case (byte_in)
               8'h66:   op16_d  = 1'b1;
               8'h67:   adr16_d = 1'b1;
               8'hF0:   lock_d  = 1'b1;
               8'hF3:   rep_d   = 2'b01;
               8'hF2:   rep_d   = 2'b10;
               8'h26:   seg_d   = 3'd0;
               8'h2E:   seg_d   = 3'd1;
               8'h36:   seg_d   = 3'd2;
               8'h3E:   seg_d   = 3'd3;
               8'h64:   seg_d   = 3'd4;
               8'h65:   seg_d   = 3'd5;
               default: ;
            endcase
            // saturating count; only "more than MAX" matters
            if (pcnt_q != PC_SAT) pcnt_d = pcnt_q + PCW'(1);
            if (pcnt_q >= PC_MAX) bad_d = 1'b1;
            if (byte_last)        bad_d = 1'b1;
         end else if (state_q == S_PREFIX && byte_in == 8'h0F) begin
            esc_d = 1'b1;
            if (byte_last) bad_d = 1'b1;
         end else begin
            // len_q is 0 in PREFIX/ESCAPE, so byte 0 lands at index 0
            if (len_q < BODY_MAX) begin
               for (int i = 0; i < BODY_BYTES; i++) begin
                  if (len_q == 4'(i)) instr_d[8*i +: 8] = byte_in;
               end
               len_d = len_q + 4'd1;
            end else begin
               bad_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_q <= '0;
         esc_q   <= 1'b0;
         op16_q  <= 1'b0;
         adr16_q <= 1'b0;
         rep_q   <= 2'b00;
         lock_q  <= 1'b0;
         seg_q   <= 3'b111;
         len_q   <= 4'd0;
         pcnt_q  <= '0;
         bad_q   <= 1'b0;
      end else begin
         instr_q <= instr_d;
         esc_q   <= esc_d;
         op16_q  <= op16_d;
         adr16_q <= adr16_d;
         rep_q   <= rep_d;
         lock_q  <= lock_d;
         seg_q   <= seg_d;
         len_q   <= len_d;
         pcnt_q  <= pcnt_d;
         bad_q   <= bad_d;
      end
   end

   assign unescaped_instr      = instr_q;
   assign escaped_0f           = esc_q;
   assign prefix_operand_16bit = op16_q;
   assign prefix_address_16bit = adr16_q;
   assign prefix_rep           = rep_q;
   assign prefix_lock          = lock_q;
   assign prefix_seg           = seg_q;
   assign body_len             = len_q;
   assign instr_bad            = bad_q;

endmodule

// File: tb/tb_decode_prefix_collect.sv
// Scoreboard bench for decode_prefix_collect.
// Expected records come from a byte-list parser model; a monitor pops them.
module tb_decode_prefix_collect;

   typedef logic [7:0] bq_t[$];

   typedef struct packed {
      logic [71:0] instr;
      logic        esc;
      logic        op16;
      logic        adr16;
      logic [1:0]  rep;
      logic        lock;
      logic [2:0]  seg;
      logic [3:0]  len;
      logic        bad;
   } rec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_last;
   logic        byte_ready;
   logic        instr_valid;
   logic        instr_ready;
   logic [71:0] unescaped_instr;
   logic        escaped_0f;
   logic        prefix_operand_16bit;
   logic        prefix_address_16bit;
   logic [1:0]  prefix_rep;
   logic        prefix_lock;
   logic [2:0]  prefix_seg;
   logic [3:0]  body_len;
   logic        instr_bad;

   int   vectors = 0;
   int   miscompares = 0;
   bit   hold_low = 1'b0;
   rec_t sb[$];

   logic [7:0] pfx_tab [11] = '{8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3,
                               8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65};

   decode_prefix_collect dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .byte_in              (byte_in),
      .byte_valid           (byte_valid),
      .byte_last            (byte_last),
      .byte_ready           (byte_ready),
      .instr_valid          (instr_valid),
      .instr_ready          (instr_ready),
      .unescaped_instr      (unescaped_instr),
      .escaped_0f           (escaped_0f),
      .prefix_operand_16bit (prefix_operand_16bit),
      .prefix_address_16bit (prefix_address_16bit),
      .prefix_rep           (prefix_rep),
      .prefix_lock          (prefix_lock),
      .prefix_seg           (prefix_seg),
      .body_len             (body_len),
      .instr_bad            (instr_bad)
   );

   always #5 clk = ~clk;

   function automatic rec_t cur();
      rec_t r;
      r.instr = unescaped_instr;
      r.esc   = escaped_0f;
      r.op16  = prefix_operand_16bit;
      r.adr16 = prefix_address_16bit;
      r.rep   = prefix_rep;
      r.lock  = prefix_lock;
      r.seg   = prefix_seg;
      r.len   = body_len;
      r.bad   = instr_bad;
      return r;
   endfunction

   function automatic bit is_pfx(input logic [7:0] b);
      for (int k = 0; k < 11; k++) if (pfx_tab[k] == b) return 1'b1;
      return 1'b0;
   endfunction

   // Parse a whole instruction: leading prefixes, optional escape, body.
   function automatic rec_t model(input bq_t b);
      rec_t e;
      int   i;
      int   cnt;
      e = '0;
      e.seg = 3'b111;
      i = 0;
      cnt = 0;
      while (i < b.size() && is_pfx(b[i])) begin
         case (b[i])
            8'h66: e.op16 = 1'b1;
            8'h67: e.adr16 = 1'b1;
            8'hF0: e.lock = 1'b1;
            8'hF3: e.rep = 2'b01;
            8'hF2: e.rep = 2'b10;
            8'h26: e.seg = 3'd0;
            8'h2E: e.seg = 3'd1;
            8'h36: e.seg = 3'd2;
            8'h3E: e.seg = 3'd3;
            8'h64: e.seg = 3'd4;
            default: e.seg = 3'd5;
         endcase
         cnt++;
         i++;
      end
      if (cnt > 4) e.bad = 1'b1;
      if (i < b.size() && b[i] == 8'h0F) begin
         e.esc = 1'b1;
         i++;
      end
      if (i == b.size()) e.bad = 1'b1;
      for (int k = i; k < b.size(); k++) begin
         if (k - i < 9) begin
            e.instr[8*(k-i) +: 8] = b[k];
            e.len = 4'(k - i + 1);
         end else begin
            e.bad = 1'b1;
         end
      end
      return e;
   endfunction

   task automatic fail_fatal(input string what);
      miscompares++;
      $display("FAIL %s: no progress within bound", what);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $fatal(1, "timeout");
   endtask

   task automatic put(input logic [7:0] b, input logic last);
      int   n;
      logic acc;
      n = 0;
      byte_in = b;
      byte_valid = 1'b1;
      byte_last = last;
      forever begin
         @(negedge clk);
         acc = byte_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         n++;
         if (n > 400) fail_fatal("byte_accept");
      end
      byte_valid = 1'b0;
      byte_last = 1'b0;
      byte_in = 8'($urandom);
   endtask

   task automatic send(input bq_t b);
      sb.push_back(model(b));
      for (int k = 0; k < b.size(); k++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         put(b[k], k == b.size() - 1);
      end
      vectors++;
      if (instr_valid !== 1'b1) begin
         miscompares++;
         $display("FAIL latency: instr_valid=%b required 1", instr_valid);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d pending required 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic check_reset_state(input string what);
      rec_t r;
      r = '0;
      r.seg = 3'b111;
      vectors++;
      if (cur() !== r || instr_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: got %h v=%b required %h v=0",
                  what, cur(), instr_valid, r);
      end
   endtask

   initial begin
      instr_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         instr_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // monitor / scoreboard
   initial begin
      rec_t snap;
      rec_t e;
      bit   held;
      held = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (held) begin
               vectors++;
               if (instr_valid !== 1'b1 || cur() !== snap) begin
                  miscompares++;
                  $display("FAIL hold_stable: got %h v=%b required %h v=1",
                           cur(), instr_valid, snap);
               end
            end
            if (instr_valid === 1'b1) begin
               vectors++;
               if (byte_ready !== 1'b0) begin
                  miscompares++;
                  $display("FAIL byte_ready_hold: got %b required 0", byte_ready);
               end
               if (instr_ready) begin
                  held = 1'b0;
                  vectors++;
                  if (sb.size() == 0) begin
                     miscompares++;
                     $display("FAIL unexpected_instr: got %h required none", cur());
                  end else begin
                     e = sb.pop_front();
                     if (cur() !== e) begin
                        miscompares++;
                        $display("FAIL instr: got %h required %h", cur(), e);
                     end
                  end
               end else begin
                  snap = cur();
                  held = 1'b1;
               end
            end else begin
               held = 1'b0;
            end
         end
      end
   end

   initial begin
      bq_t q;
      int  n;
      rst_n = 1'b0;
      byte_in = 8'h00;
      byte_valid = 1'b0;
      byte_last = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("reset_outputs");
      vectors++;
      if (byte_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_byte_ready: got %b required 1", byte_ready);
      end
      rst_n = 1'b1;

      q = '{8'h66, 8'h67, 8'h01, 8'hD8};
      send(q);
      q = '{8'hF3, 8'h0F, 8'hB8, 8'hC1};
      send(q);
      q = '{8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h2E, 8'h90};
      send(q);
      q = '{8'h81, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
            8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
      send(q);
      q = '{8'h0F, 8'h0F, 8'h05};
      send(q);
      q = '{8'h26, 8'h65, 8'hF2, 8'hF3, 8'h0F};
      send(q);
      drain();

      // stall the decode stage for 5 cycles with bytes offered
      hold_low = 1'b1;
      @(posedge clk);
      #1;
      q = '{8'hF0, 8'h36, 8'h87, 8'h03};
      send(q);
      byte_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         byte_in = 8'($urandom);
         @(negedge clk);
         vectors++;
         if (byte_ready !== 1'b0 || instr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL stall: byte_ready=%b instr_valid=%b required 0/1",
                     byte_ready, instr_valid);
         end
         @(posedge clk);
         #1;
      end
      byte_valid = 1'b0;
      hold_low = 1'b0;
      q = '{8'h67, 8'h8B, 8'h04, 8'h24};
      send(q);
      drain();

      // asynchronous reset mid-instruction
      put(8'h66, 1'b0);
      put(8'h0F, 1'b0);
      put(8'hAF, 1'b0);
      rst_n = 1'b0;
      #1;
      check_reset_state("async_reset");
      @(posedge clk);
      #1;
      check_reset_state("reset_held");
      rst_n = 1'b1;
      q = '{8'h66};
      send(q);
      drain();

      for (int t = 0; t < 150; t++) begin
         q = {};
         n = $urandom_range(0, 6);
         for (int k = 0; k < n; k++) q.push_back(pfx_tab[$urandom_range(0, 10)]);
         if ($urandom_range(0, 1) == 1) q.push_back(8'h0F);
         n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 11);
         if (q.size() == 0 && n == 0) n = 1;
         for (int k = 0; k < n; k++) q.push_back(8'($urandom));
         send(q);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
